// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Byte-addressed little-endian data memory for the multicycle RISC-V
//   datapath. Supports RV32I byte/half/word loads (sign/zero extended) and
//   stores through a valid/ready request with a registered one-cycle response.
//   After reset a clear engine zeroes [DATA_BASE, DEPTH) one word per cycle.
//   The program region below DATA_BASE is left untouched.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid         request present this cycle
//   req_write         1 = store, 0 = load
//   funct3            RV32I size/sign code
//   address           byte address
//   write_data        store data (low bits used for sb/sh)
//   req_ready         high whenever a request can be accepted (READY state)
//   rsp_valid         one-cycle pulse in the cycle after an accepted request
//   rsp_data          load result; 0 for stores and errors
//   error             misaligned, illegal funct3 or out of range (with rsp_valid)
//   busy              clear engine running
module data_memory_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_BASE  = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        error,
    output logic        busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 4);
    localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(DATA_BASE);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [7:0]            mem [DEPTH];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset)
            // An empty data region needs no clearing.
            state <= (DATA_BASE >= DEPTH) ? READY : CLEAR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_PTR) state_next = READY;
            default: state_next = READY;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign req_ready = (state == READY);

    // ---------------- request decode ----------------
    logic                  accept, out_of_range, bad_f3, misaligned, err;
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           load_val;

    assign accept       = req_valid && req_ready;
    assign out_of_range = |address[31:ADDR_WIDTH];
    assign bad_f3       = req_write ? (funct3[2] || funct3[1:0] == 2'b11)
                                    : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
    assign misaligned   = (funct3[1:0] == 2'b01 && address[0]) ||
                          (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
    assign err          = out_of_range || bad_f3 || misaligned;

    // Byte indices wrap inside the array; only used when the access is legal,
    // and legal accesses are aligned so they never actually wrap.
    assign a0 = address[ADDR_WIDTH-1:0];
    assign a1 = a0 + ADDR_WIDTH'(1);
    assign a2 = a0 + ADDR_WIDTH'(2);
    assign a3 = a0 + ADDR_WIDTH'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        load_val = 32'h0;
        case (funct3)
            3'b000:  load_val = {{24{b0[7]}}, b0};
            3'b001:  load_val = {{16{b1[7]}}, b1, b0};
            3'b010:  load_val = {b3, b2, b1, b0};
            3'b100:  load_val = {24'h0, b0};
            3'b101:  load_val = {16'h0, b1, b0};
            default: load_val = 32'h0;
        endcase
    end

    // ---------------- memory + clear engine ----------------
    // Memory itself has no reset; only the clear engine zeroes the data region.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr <= BASE_PTR;
        end else if (state == CLEAR) begin
            mem[clr_ptr]                  <= 8'h00;
            mem[clr_ptr + ADDR_WIDTH'(1)] <= 8'h00;
            mem[clr_ptr + ADDR_WIDTH'(2)] <= 8'h00;
            mem[clr_ptr + ADDR_WIDTH'(3)] <= 8'h00;
            clr_ptr <= clr_ptr + ADDR_WIDTH'(4);
        end else if (accept && req_write && !err) begin
            mem[a0] <= write_data[7:0];
            if (funct3[1:0] != 2'b00) mem[a1] <= write_data[15:8];
            if (funct3[1:0] == 2'b10) begin
                mem[a2] <= write_data[23:16];
                mem[a3] <= write_data[31:24];
            end
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            error     <= 1'b0;
        end else begin
            rsp_valid <= accept;
            error     <= accept && err;
            rsp_data  <= (accept && !req_write && !err) ? load_val : 32'h0;
        end
    end
endmodule
